mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between instruction fetch (read-only) and the data
//  requester (load/store). It sits between fetch/data stages and the memory module.
//  It grants one transaction at a time, sequences read bursts beat-by-beat, stalls
//  the losing requester, and bounds fetch starvation under continuous data traffic.
// PARAMETERS
//  ADDR_WIDTH  32  address width of all address ports
//  DATA_WIDTH  32  data width of all data ports
//  MAX_WAIT    4   fetch losses tolerated before fetch is forced to win (1..15)
// PORTS
//  clock            in   1   system clock, posedge
//  reset            in   1   asynchronous, active-high reset
//  f_req            in   1   fetch read request; held until f_gnt
//  f_addr           in   AW  fetch word address
//  f_access_size    in   2   00=1, 01=4, 10=8, 11=16 words
//  f_gnt            out  1   one-cycle pulse: fetch request issued to memory
//  f_rvalid         out  1   f_rdata valid; one pulse per beat
//  f_rdata          out  DW  fetch read beat
//  f_stall          out  1   f_req && state!=FETCH (combinational)
//  d_req            in   1   data request; held until d_gnt
//  d_rw             in   1   1=read, 0=write
//  d_addr           in   AW  data address
//  d_wdata          in   DW  write data (single word)
//  d_access_size    in   2   read burst size; ignored for writes (always 1 word)
//  d_gnt            out  1   one-cycle pulse: data request issued
//  d_rvalid         out  1   d_rdata valid; one pulse per beat
//  d_rdata          out  DW  data read beat
//  mem_address      out  AW  to memory address
//  mem_data_in      out  DW  to memory data_in
//  mem_access_size  out  2   to memory access_size
//  mem_rw           out  1   to memory rw (1=read, 0=write)
//  mem_enable       out  1   to memory enable; one-cycle pulse per transaction
//  mem_busy         in   1   from memory busy
//  mem_data_out     in   DW  from memory data_out
// BEHAVIOUR
//  - Reset (async): state=IDLE, beat/wait counters=0, all outputs 0 (mem_rw=0).
//  - States: IDLE, FETCH, DATA, DRAIN. All mem_*, gnt and rvalid outputs are registered.
//  - IDLE: no grant while mem_busy=1. Otherwise, at the edge ending cycle T:
//    - d_req wins over f_req.
//    - Exception: wait_cnt==MAX_WAIT && f_req: fetch wins.
//  - Cycle T+1 (new state FETCH/DATA):
//    - mem_enable=1; mem_address/rw/access_size/data_in copied from the winner.
//    - Winner gnt=1. Both are one cycle only.
//  - Read of N words: memory presents beat k in cycle T+2+k.
//    - The arbiter registers the beat; owner rvalid=1 and rdata=beat in cycle T+3+k.
//  - After the last beat is captured, the state goes to DRAIN if mem_busy=1, else IDLE.
//    DRAIN exits to IDLE when mem_busy=0.
//  - Data write: mem_rw=0, mem_access_size forced 00, no rvalid. State returns to IDLE
//    at T+2, giving 2 cycles per write.
//  - A new grant needs a cycle in IDLE, so there is one turnaround cycle between transactions.
//  - wait_cnt (4b): +1 each IDLE grant where d_req beats a pending f_req, saturating at
//    MAX_WAIT. It clears when fetch is granted or f_req=0.
//  - A request dropped before gnt is never issued; no partial state is kept.
//  - rdata holds its last value when rvalid=0; the non-owner rvalid stays 0.
//  - Reset mid-burst: remaining beats are discarded and no rvalid follows. After release,
//    IDLE waits for mem_busy=0 before granting.
//  - f_stall is 1 in DATA/DRAIN and in IDLE whenever f_req=1.
// TESTING
//  1. f_req, f_addr=32'h80020000, size 00, mem returns 32'h27bdfff0
//     -> mem_enable+f_gnt at T+1; f_rvalid, f_rdata=27bdfff0 at T+3; IDLE at T+4.
//  2. f_req size 01 at 32'h80020010 -> 4 f_rvalid pulses in T+3..T+6, data in order;
//     mem_enable high exactly 1 cycle.
//  3. d_req write 32'h80020100 <- 32'hdeadbeef
//     -> mem_rw=0, mem_access_size=00, mem_data_in=deadbeef at T+1; d_gnt=1; no rvalid.
//  4. f_req and d_req read held continuously, MAX_WAIT=4
//     -> 4 data grants, then 1 fetch grant, repeating; f_stall=1 except in FETCH.
//  5. reset pulsed during beat 2 of a 16-word read with mem_busy held 1 for 5 more cycles
//     -> no rvalid after reset; first new grant only after mem_busy=0.
//  6. d_req asserted 1 cycle then dropped while FETCH in progress
//     -> no d_gnt, no memory write, wait_cnt unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [1:0]            f_access_size;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;
  logic                  f_stall;

  logic                  d_req;
  logic                  d_rw;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [1:0]            d_access_size;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [1:0]            mem_access_size;
  logic                  mem_rw;
  logic                  mem_enable;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  f_req, f_addr, f_access_size,
    output f_gnt, f_rvalid, f_rdata, f_stall,
    input  d_req, d_rw, d_addr, d_wdata, d_access_size,
    output d_gnt, d_rvalid, d_rdata,
    output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    input  mem_busy, mem_data_out
  );

  modport master (
    output f_req, f_addr, f_access_size,
    input  f_gnt, f_rvalid, f_rdata, f_stall,
    output d_req, d_rw, d_addr, d_wdata, d_access_size,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    output mem_busy, mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store requester,
// sequencing read bursts beat by beat and bounding fetch starvation.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   io_bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [3:0] L_MAX_WAIT = 4'(MAX_WAIT);

  logic [1:0]            r_state;
  logic [3:0]            r_wait_cnt;
  logic [4:0]            r_beat_cnt;
  logic [4:0]            r_beats;
  logic                  r_is_read;
  logic                  r_f_gnt;
  logic                  r_d_gnt;
  logic                  r_f_rvalid;
  logic                  r_d_rvalid;
  logic [DATA_WIDTH-1:0] r_f_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data_in;
  logic [1:0]            r_mem_access_size;
  logic                  r_mem_rw;
  logic                  r_mem_enable;

  logic w_grant;
  logic w_fetch_wins;
  logic w_xfer;
  logic w_capture;

  function automatic logic [4:0] size_beats(input logic [1:0] size);
    case (size)
      2'b00:   size_beats = 5'd1;
      2'b01:   size_beats = 5'd4;
      2'b10:   size_beats = 5'd8;
      default: size_beats = 5'd16;
    endcase
  endfunction

  assign w_grant      = (r_state == S_IDLE) && !io_bus.mem_busy && (io_bus.f_req || io_bus.d_req);
  assign w_fetch_wins = io_bus.f_req && (!io_bus.d_req || (r_wait_cnt == L_MAX_WAIT));
  assign w_xfer       = (r_state == S_FETCH) || (r_state == S_DATA);
  // The enable cycle itself carries no beat; memory starts returning data one cycle later.
  assign w_capture    = w_xfer && r_is_read && !r_mem_enable && (r_beat_cnt != r_beats);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_wait_cnt        <= '0;
      r_beat_cnt        <= '0;
      r_beats           <= '0;
      r_is_read         <= 1'b0;
      r_f_gnt           <= 1'b0;
      r_d_gnt           <= 1'b0;
      r_f_rvalid        <= 1'b0;
      r_d_rvalid        <= 1'b0;
      r_f_rdata         <= '0;
      r_d_rdata         <= '0;
      r_mem_address     <= '0;
      r_mem_data_in     <= '0;
      r_mem_access_size <= '0;
      r_mem_rw          <= 1'b0;
      r_mem_enable      <= 1'b0;
    end else begin
      r_mem_enable <= 1'b0;
      r_f_gnt      <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_f_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      if (!io_bus.f_req) r_wait_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_mem_enable <= 1'b1;
            r_beat_cnt   <= '0;
            if (w_fetch_wins) begin
              r_state           <= S_FETCH;
              r_f_gnt           <= 1'b1;
              r_mem_address     <= io_bus.f_addr;
              r_mem_data_in     <= '0;
              r_mem_access_size <= io_bus.f_access_size;
              r_mem_rw          <= 1'b1;
              r_beats           <= size_beats(io_bus.f_access_size);
              r_is_read         <= 1'b1;
              r_wait_cnt        <= '0;
            end else begin
              r_state           <= S_DATA;
              r_d_gnt           <= 1'b1;
              r_mem_address     <= io_bus.d_addr;
              r_mem_data_in     <= io_bus.d_wdata;
              r_mem_access_size <= io_bus.d_rw ? io_bus.d_access_size : 2'b00;
              r_mem_rw          <= io_bus.d_rw;
              r_beats           <= io_bus.d_rw ? size_beats(io_bus.d_access_size) : 5'd1;
              r_is_read         <= io_bus.d_rw;
              if (io_bus.f_req && (r_wait_cnt < L_MAX_WAIT))
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
          end
        end
        S_FETCH, S_DATA: begin
          if (!r_is_read) begin
            r_state <= S_IDLE;
          end else if (w_capture) begin
            r_beat_cnt <= r_beat_cnt + 5'd1;
            if (r_state == S_FETCH) begin
              r_f_rvalid <= 1'b1;
              r_f_rdata  <= io_bus.mem_data_out;
            end else begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= io_bus.mem_data_out;
            end
          end else if (!r_mem_enable) begin
            r_state <= io_bus.mem_busy ? S_DRAIN : S_IDLE;
          end
        end
        default: begin
          if (!io_bus.mem_busy) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.f_gnt           = r_f_gnt;
  assign io_bus.d_gnt           = r_d_gnt;
  assign io_bus.f_rvalid        = r_f_rvalid;
  assign io_bus.d_rvalid        = r_d_rvalid;
  assign io_bus.f_rdata         = r_f_rdata;
  assign io_bus.d_rdata         = r_d_rdata;
  assign io_bus.mem_address     = r_mem_address;
  assign io_bus.mem_data_in     = r_mem_data_in;
  assign io_bus.mem_access_size = r_mem_access_size;
  assign io_bus.mem_rw          = r_mem_rw;
  assign io_bus.mem_enable      = r_mem_enable;
  assign io_bus.f_stall         = io_bus.f_req && (r_state != S_FETCH);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-schedule model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int words_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (2 << size);
  endfunction

  // Model: a granted transaction occupies a fixed schedule of cycles relative to its grant cycle.
  int          cyc = 0;
  bit          m_in_txn = 0, m_drain = 0, m_owner_f = 0, m_read = 0;
  int          m_t = 0, m_n = 0, m_wait = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_rw = 1'b0;
  logic [1:0]    m_size = '0;
  logic [DW-1:0] m_wdata = '0, m_prev_data = '0, m_f_rdata = '0, m_d_rdata = '0;

  always @(negedge clock) begin
    int  rel;
    bit  e_en, e_rv, fwin;
    if (reset) begin
      m_in_txn = 0; m_drain = 0; m_wait = 0;
      m_f_rdata = '0; m_d_rdata = '0;
      chk("rst_mem_enable", bus.mem_enable, 1'b0);
      chk("rst_mem_rw", bus.mem_rw, 1'b0);
      chk("rst_gnt", {bus.f_gnt, bus.d_gnt}, 2'b00);
      chk("rst_rvalid", {bus.f_rvalid, bus.d_rvalid}, 2'b00);
      chk("rst_rdata", {bus.f_rdata, bus.d_rdata}, 64'h0);
      chk("rst_mem_address", bus.mem_address, '0);
    end else begin
      rel  = cyc - m_t;
      e_en = m_in_txn && (rel == 1);
      e_rv = m_in_txn && m_read && (rel >= 3) && (rel < 3 + m_n);
      if (e_rv && m_owner_f)  m_f_rdata = m_prev_data;
      if (e_rv && !m_owner_f) m_d_rdata = m_prev_data;
      chk("mem_enable", bus.mem_enable, e_en);
      chk("f_gnt", bus.f_gnt, e_en && m_owner_f);
      chk("d_gnt", bus.d_gnt, e_en && !m_owner_f);
      chk("f_rvalid", bus.f_rvalid, e_rv && m_owner_f);
      chk("d_rvalid", bus.d_rvalid, e_rv && !m_owner_f);
      chk("f_rdata", bus.f_rdata, m_f_rdata);
      chk("d_rdata", bus.d_rdata, m_d_rdata);
      chk("f_stall", bus.f_stall, bus.f_req && !(m_in_txn && m_owner_f));
      if (e_en) begin
        chk("mem_address", bus.mem_address, m_addr);
        chk("mem_rw", bus.mem_rw, m_rw);
        chk("mem_access_size", bus.mem_access_size, m_size);
        if (!m_rw) chk("mem_data_in", bus.mem_data_in, m_wdata);
      end

      if (m_in_txn) begin
        if (rel == (m_read ? 2 + m_n : 1)) begin
          m_in_txn = 0;
          m_drain  = m_read && bus.mem_busy;
        end
      end else if (m_drain) begin
        if (!bus.mem_busy) m_drain = 0;
      end else if (!bus.mem_busy && (bus.f_req || bus.d_req)) begin
        fwin      = bus.f_req && (!bus.d_req || m_wait == MW);
        m_in_txn  = 1;
        m_t       = cyc;
        m_owner_f = fwin;
        if (fwin) begin
          m_read = 1; m_n = words_of(bus.f_access_size);
          m_addr = bus.f_addr; m_rw = 1'b1; m_size = bus.f_access_size;
          m_wait = 0;
        end else begin
          m_read = bus.d_rw; m_n = bus.d_rw ? words_of(bus.d_access_size) : 1;
          m_addr = bus.d_addr; m_rw = bus.d_rw;
          m_size = bus.d_rw ? bus.d_access_size : 2'b00;
          m_wdata = bus.d_wdata;
          if (bus.f_req) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
        end
      end
      if (!bus.f_req) m_wait = 0;
    end
    m_prev_data = bus.mem_data_out;
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, rv_cnt, gcnt, d_cnt;
    bit found;
    string pat;
    bus.f_req = 0; bus.f_addr = '0; bus.f_access_size = 0;
    bus.d_req = 0; bus.d_rw = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_access_size = 0;
    bus.mem_busy = 0; bus.mem_data_out = '0;
    #1 reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("post_rst_stall", bus.f_stall, 1'b0);
    chk("post_rst_rw", bus.mem_rw, 1'b0);

    // single-word fetch
    @(posedge clock); #1;
    bus.mem_data_out = 32'h27bdfff0;
    bus.f_req = 1; bus.f_addr = 32'h80020000; bus.f_access_size = 2'b00;
    @(negedge clock); chk("t1_stall_idle", bus.f_stall, 1'b1);
    @(posedge clock); #1; bus.f_req = 0;
    @(negedge clock);
    chk("t1_gnt", bus.f_gnt, 1'b1);
    chk("t1_en", bus.mem_enable, 1'b1);
    chk("t1_addr", bus.mem_address, 32'h80020000);
    chk("t1_rw", bus.mem_rw, 1'b1);
    @(negedge clock); chk("t1_rv_t2", bus.f_rvalid, 1'b0);
    @(negedge clock); chk("t1_rv_t3", bus.f_rvalid, 1'b1); chk("t1_data", bus.f_rdata, 32'h27bdfff0);
    @(negedge clock); chk("t1_rv_t4", bus.f_rvalid, 1'b0); chk("t1_hold", bus.f_rdata, 32'h27bdfff0);

    // 4-word fetch burst
    @(posedge clock); #1;
    bus.f_req = 1; bus.f_addr = 32'h80020010; bus.f_access_size = 2'b01;
    @(negedge clock);
    en_cnt = 0; rv_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if (i == 1) bus.f_req = 0;
      bus.mem_data_out = 32'(32'h2000 + i - 2);
      @(negedge clock);
      if (bus.mem_enable) en_cnt++;
      if (bus.f_rvalid) begin
        chk("t2_beat_data", bus.f_rdata, 32'(32'h2000 + rv_cnt));
        chk("t2_beat_cycle", i, rv_cnt + 3);
        rv_cnt++;
      end
    end
    chk("t2_enable_cycles", en_cnt, 1);
    chk("t2_beats", rv_cnt, 4);

    // single write, burst size must be forced to one word
    @(posedge clock); #1;
    bus.d_req = 1; bus.d_rw = 0; bus.d_addr = 32'h80020100; bus.d_wdata = 32'hdeadbeef;
    bus.d_access_size = 2'b11;
    @(posedge clock); #1; bus.d_req = 0;
    @(negedge clock);
    chk("t3_gnt", bus.d_gnt, 1'b1);
    chk("t3_rw", bus.mem_rw, 1'b0);
    chk("t3_size", bus.mem_access_size, 2'b00);
    chk("t3_wdata", bus.mem_data_in, 32'hdeadbeef);
    rv_cnt = 0;
    repeat (4) begin @(negedge clock); if (bus.d_rvalid || bus.f_rvalid) rv_cnt++; end
    chk("t3_no_rvalid", rv_cnt, 0);

    // starvation bound: both held
    @(posedge clock); #1;
    bus.f_req = 1; bus.f_access_size = 2'b00; bus.f_addr = 32'h80021000;
    bus.d_req = 1; bus.d_rw = 1; bus.d_access_size = 2'b00; bus.d_addr = 32'h80030000;
    gcnt = 0; pat = "";
    for (int i = 0; i < 200 && gcnt < 10; i++) begin
      @(negedge clock);
      if (bus.f_gnt) begin pat = {pat, "F"}; gcnt++; end
      if (bus.d_gnt) begin pat = {pat, "D"}; gcnt++; end
    end
    @(posedge clock); #1; bus.f_req = 0; bus.d_req = 0;
    chk("t4_grant_count", gcnt, 10);
    chk("t4_pattern_ok", (pat == "DDDDFDDDDF"), 1'b1);
    repeat (6) @(posedge clock);

    // data request pulsed while fetch busy is never issued
    #1; bus.f_req = 1; bus.f_access_size = 2'b01;
    @(posedge clock); #1; bus.f_req = 0;
    @(posedge clock); #1; bus.d_req = 1; bus.d_rw = 0; bus.d_wdata = 32'h12345678;
    @(posedge clock); #1; bus.d_req = 0;
    d_cnt = 0; en_cnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (bus.d_gnt) d_cnt++;
      if (bus.mem_enable) en_cnt++;
    end
    chk("t6_no_dgnt", d_cnt, 0);
    chk("t6_no_enable", en_cnt, 0);

    // reset in the middle of a 16-word burst
    @(posedge clock); #1;
    bus.f_req = 1; bus.f_access_size = 2'b11; bus.f_addr = 32'h80040000;
    @(posedge clock); #1; bus.f_req = 0; bus.mem_busy = 1;
    rv_cnt = 0;
    for (int i = 0; i < 40 && rv_cnt < 2; i++) begin
      @(negedge clock);
      if (bus.f_rvalid) rv_cnt++;
    end
    chk("t5_two_beats", rv_cnt, 2);
    @(posedge clock); #1; reset = 1; bus.f_req = 1; bus.f_access_size = 2'b00;
    @(posedge clock); #1; reset = 0;
    rv_cnt = 0; gcnt = 0;
    repeat (5) begin
      @(negedge clock);
      if (bus.f_rvalid || bus.d_rvalid) rv_cnt++;
      if (bus.f_gnt || bus.d_gnt || bus.mem_enable) gcnt++;
    end
    chk("t5_no_rvalid", rv_cnt, 0);
    chk("t5_no_gnt_busy", gcnt, 0);
    @(posedge clock); #1; bus.mem_busy = 0;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clock);
      if (bus.f_gnt) found = 1;
    end
    chk("t5_gnt_after_busy", found, 1'b1);
    @(posedge clock); #1; bus.f_req = 0;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock); #1;
      if (bus.f_req && bus.f_gnt) bus.f_req = 0;
      if (!bus.f_req && $urandom_range(0, 2) == 0) begin
        bus.f_req = 1; bus.f_addr = $urandom; bus.f_access_size = 2'($urandom_range(0, 3));
      end
      if (bus.d_req && bus.d_gnt) bus.d_req = 0;
      else if (bus.d_req && $urandom_range(0, 15) == 0) bus.d_req = 0;
      if (!bus.d_req && $urandom_range(0, 2) == 0) begin
        bus.d_req = 1; bus.d_rw = 1'($urandom_range(0, 1)); bus.d_addr = $urandom;
        bus.d_wdata = $urandom; bus.d_access_size = 2'($urandom_range(0, 3));
      end
      bus.mem_busy = ($urandom_range(0, 4) == 0);
      bus.mem_data_out = $urandom;
    end
    @(posedge clock); #1; bus.f_req = 0; bus.d_req = 0; bus.mem_busy = 0;
    repeat (30) @(posedge clock);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
